// File: rtl/stim_sig_pkg.sv
// Shared types and constants for the stimulus generator / signature checker.
// Also holds the LFSR and MISR step functions.
package stim_sig_pkg;

   localparam int unsigned STIM_W = 8;
   localparam int unsigned SIG_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [STIM_W-1:0] LFSR_TAPS     = 8'hB8;
   localparam logic [SIG_W-1:0]  MISR_POLY     = 16'h1021;
   localparam logic [STIM_W-1:0] ZERO_SEED_SUB = 8'h01;

   // Fibonacci step: feedback is the parity of the tapped bits (7,5,4,3)
   function automatic logic [STIM_W-1:0] lfsr_next(input logic [STIM_W-1:0] q);
      return {q[STIM_W-2:0], ^(q & LFSR_TAPS)};
   endfunction

   function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]  sig,
                                                  input logic [STIM_W-1:0] data);
      logic [SIG_W-1:0] shifted;
      shifted = {sig[SIG_W-2:0], 1'b0};
      if (sig[SIG_W-1]) begin
         shifted = shifted ^ MISR_POLY;
      end
      return shifted ^ {{(SIG_W-STIM_W){1'b0}}, data};
   endfunction

endpackage

// File: rtl/stim_sig_if.sv
// Control and circuit-under-test bus of the signature checker.
// master = checker side, slave = harness / circuit side.
interface stim_sig_if;
   import stim_sig_pkg::*;

   logic              start;
   logic [STIM_W-1:0] seed;
   logic [SIG_W-1:0]  expected;
   logic [STIM_W-1:0] resp_in;
   logic [STIM_W-1:0] stim_out;
   logic              dut_clear;
   logic              busy;
   logic              done;
   logic [SIG_W-1:0]  signature;
   logic              pass;

   modport master (
      input  start, seed, expected, resp_in,
      output stim_out, dut_clear, busy, done, signature, pass
   );

   modport slave (
      output start, seed, expected, resp_in,
      input  stim_out, dut_clear, busy, done, signature, pass
   );

endinterface

// File: rtl/stim_sig_checker_misr16.sv
// 16-bit multiple-input signature register over an 8-bit response.
// init clears the signature and takes priority over en.
module misr16
   import stim_sig_pkg::*;
(
   input  logic              clk,
   input  logic              clear_n,
   input  logic              init,
   input  logic              en,
   input  logic [STIM_W-1:0] data,
   output logic [SIG_W-1:0]  sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (init) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = misr_next(sig_q, data);
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/stim_sig_checker.sv
// LFSR stimulus generator and MISR signature checker for an 8-bit circuit.
// A run applies N_VECTORS vectors, waits DUT_LATENCY cycles, then reports.
module stim_sig_checker
   import stim_sig_pkg::*;
#(
   parameter int unsigned N_VECTORS   = 256,
   parameter int unsigned DUT_LATENCY = 0
)
(
   input  logic       clk,
   input  logic       clear_n,
   stim_sig_if.master bus
);

   localparam int unsigned     CNT_W      = $clog2(N_VECTORS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_VECTORS - 1);
   localparam logic [1:0]      FLUSH_LAST = (DUT_LATENCY > 0) ? 2'(DUT_LATENCY - 1) : 2'd0;

   state_t            state_q, state_d;
   logic [STIM_W-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        flush_q, flush_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              dut_clear_q, dut_clear_d;
   logic              misr_init_c;
   logic              stim_valid_c;
   logic              cap_valid_c;
   logic [SIG_W-1:0]  sig_c;

   // Next-state logic; lfsr_q is the presented vector, so it only steps between vectors
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      cnt_d       = cnt_q;
      flush_d     = flush_q;
      misr_init_c = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d     = RUN;
               lfsr_d      = (bus.seed == '0) ? ZERO_SEED_SUB : bus.seed;
               cnt_d       = '0;
               flush_d     = '0;
               misr_init_c = 1'b1;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = (DUT_LATENCY > 0) ? FLUSH : DONE;
            end else begin
               lfsr_d = lfsr_next(lfsr_q);
            end
         end
         FLUSH: begin
            flush_d = flush_q + 2'd1;
            if (flush_q == FLUSH_LAST) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d      = (state_d == RUN) || (state_d == FLUSH);
      done_d      = (state_d == DONE);
      dut_clear_d = !busy_d;
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= IDLE;
         lfsr_q      <= '0;
         cnt_q       <= '0;
         flush_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dut_clear_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         cnt_q       <= cnt_d;
         flush_q     <= flush_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dut_clear_q <= dut_clear_d;
      end
   end

   assign stim_valid_c = (state_q == RUN);

   // Align the capture strobe with the circuit's response latency
   generate
      if (DUT_LATENCY == 0) begin : g_no_pipe
         assign cap_valid_c = stim_valid_c;
      end else begin : g_pipe
         logic [DUT_LATENCY-1:0] vpipe_q;
         logic [DUT_LATENCY-1:0] vpipe_d;

         always_comb begin
            vpipe_d = (vpipe_q << 1) | DUT_LATENCY'(stim_valid_c);
         end

         always_ff @(posedge clk or negedge clear_n) begin
            if (!clear_n) begin
               vpipe_q <= '0;
            end else begin
               vpipe_q <= vpipe_d;
            end
         end

         assign cap_valid_c = vpipe_q[DUT_LATENCY-1];
      end
   endgenerate

   misr16 u_misr (
      .clk     (clk),
      .clear_n (clear_n),
      .init    (misr_init_c),
      .en      (cap_valid_c),
      .data    (bus.resp_in),
      .sig     (sig_c)
   );

   assign bus.stim_out  = lfsr_q;
   assign bus.dut_clear = dut_clear_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.signature = sig_c;
   assign bus.pass      = done_q && (sig_c == bus.expected);

endmodule

// File: tb/tb_stim_sig_checker.sv
// Bench for stim_sig_checker: four configurations, scoreboarded vector stream and signature.
module tb_stim_sig_checker;

   localparam int unsigned N0 = 2,   L0 = 0;
   localparam int unsigned N1 = 256, L1 = 0;
   localparam int unsigned N2 = 3,   L2 = 0;
   localparam int unsigned N3 = 2,   L3 = 1;

   logic clk;
   logic clear_n;

   logic        start_r [4];
   logic [7:0]  seed_r  [4];
   logic [15:0] exp_r   [4];
   logic [7:0]  reg_resp;

   int unsigned checks;
   int unsigned failures;
   int unsigned sel;

   logic [7:0]  p_stim;
   logic        p_clear, p_busy, p_done, p_pass;
   logic [15:0] p_sig;

   logic [7:0]  exp_stim [$];
   logic [15:0] exp_sig  [$];

   stim_sig_if b0 ();
   stim_sig_if b1 ();
   stim_sig_if b2 ();
   stim_sig_if b3 ();

   assign b0.start = start_r[0]; assign b0.seed = seed_r[0]; assign b0.expected = exp_r[0];
   assign b1.start = start_r[1]; assign b1.seed = seed_r[1]; assign b1.expected = exp_r[1];
   assign b2.start = start_r[2]; assign b2.seed = seed_r[2]; assign b2.expected = exp_r[2];
   assign b3.start = start_r[3]; assign b3.seed = seed_r[3]; assign b3.expected = exp_r[3];

   // Circuits under test: identity, all-zero, identity, registered identity
   assign b0.resp_in = b0.stim_out;
   assign b1.resp_in = 8'h00;
   assign b2.resp_in = b2.stim_out;
   always_ff @(posedge clk) reg_resp <= b3.stim_out;
   assign b3.resp_in = reg_resp;

   stim_sig_checker #(.N_VECTORS(N0), .DUT_LATENCY(L0)) u0 (.clk(clk), .clear_n(clear_n), .bus(b0));
   stim_sig_checker #(.N_VECTORS(N1), .DUT_LATENCY(L1)) u1 (.clk(clk), .clear_n(clear_n), .bus(b1));
   stim_sig_checker #(.N_VECTORS(N2), .DUT_LATENCY(L2)) u2 (.clk(clk), .clear_n(clear_n), .bus(b2));
   stim_sig_checker #(.N_VECTORS(N3), .DUT_LATENCY(L3)) u3 (.clk(clk), .clear_n(clear_n), .bus(b3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      p_stim = b0.stim_out; p_clear = b0.dut_clear; p_busy = b0.busy;
      p_done = b0.done;     p_sig   = b0.signature; p_pass = b0.pass;
      case (sel)
         1: begin
            p_stim = b1.stim_out; p_clear = b1.dut_clear; p_busy = b1.busy;
            p_done = b1.done;     p_sig   = b1.signature; p_pass = b1.pass;
         end
         2: begin
            p_stim = b2.stim_out; p_clear = b2.dut_clear; p_busy = b2.busy;
            p_done = b2.done;     p_sig   = b2.signature; p_pass = b2.pass;
         end
         3: begin
            p_stim = b3.stim_out; p_clear = b3.dut_clear; p_busy = b3.busy;
            p_done = b3.done;     p_sig   = b3.signature; p_pass = b3.pass;
         end
         default: ;
      endcase
   end

   function automatic logic [7:0] model_lfsr(input logic [7:0] q);
      logic fb;
      fb = q[7] ^ q[5] ^ q[4] ^ q[3];
      return {q[6:0], fb};
   endfunction

   function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [7:0] d);
      logic [15:0] t;
      t = {s[14:0], 1'b0};
      if (s[15]) t = t ^ 16'h1021;
      return t ^ {8'h00, d};
   endfunction

   function automatic int unsigned n_of(input int unsigned s);
      case (s)
         0: return N0;
         1: return N1;
         2: return N2;
         default: return N3;
      endcase
   endfunction

   function automatic int unsigned l_of(input int unsigned s);
      return (s == 3) ? L3 : 0;
   endfunction

   // Launch one run on instance s, scoreboard every vector, then check length and signature
   task automatic run_vectors(input int unsigned s, input logic [7:0] sd, input int unsigned poke_at);
      logic [7:0]  v, last_v, e;
      logic [15:0] sig, es;
      int unsigned n, lat, busy_cnt, clr_bad, done_at;
      bit          got_done;
      n = n_of(s); lat = l_of(s);
      v = (sd == 8'h00) ? 8'h01 : sd;
      sig = '0; last_v = v;
      for (int i = 0; i < int'(n); i++) begin
         exp_stim.push_back(v);
         sig = model_misr(sig, (s == 1) ? 8'h00 : v);
         last_v = v;
         v = model_lfsr(v);
      end
      exp_sig.push_back(sig);
      sel = s; busy_cnt = 0; clr_bad = 0; done_at = 0; got_done = 0;
      @(negedge clk);
      exp_r[s] = sig; seed_r[s] = sd; start_r[s] = 1'b1;
      @(negedge clk);
      start_r[s] = 1'b0;
      for (int unsigned k = 1; k <= n + lat + 8; k++) begin
         start_r[s] = (k == poke_at);
         if (k == poke_at) seed_r[s] = ~sd;
         if (p_done) begin
            got_done = 1; done_at = k;
            break;
         end
         if (p_busy) busy_cnt++;
         if (p_clear === p_busy) clr_bad++;
         if (exp_stim.size() > 0) begin
            e = exp_stim.pop_front();
            checks++;
            if (p_stim !== e) begin
               failures++;
               $display("FAIL stim sel=%0d cycle=%0d got=%h want=%h", s, k, p_stim, e);
            end
         end else if (p_busy) begin
            checks++;
            if (p_stim !== last_v) begin
               failures++;
               $display("FAIL flush_hold sel=%0d got=%h want=%h", s, p_stim, last_v);
            end
         end
         @(negedge clk);
      end
      start_r[s] = 1'b0;
      checks++;
      if (!got_done) begin
         failures++;
         $display("FAIL done_timeout sel=%0d got=0 want=1", s);
      end
      checks++;
      if (done_at != n + lat + 1) begin
         failures++;
         $display("FAIL run_length sel=%0d got=%0d want=%0d", s, done_at, n + lat + 1);
      end
      checks++;
      if (busy_cnt != n + lat) begin
         failures++;
         $display("FAIL busy_cycles sel=%0d got=%0d want=%0d", s, busy_cnt, n + lat);
      end
      checks++;
      if (clr_bad != 0) begin
         failures++;
         $display("FAIL dut_clear_vs_busy sel=%0d got=%0d want=0", s, clr_bad);
      end
      es = exp_sig.pop_front();
      checks++;
      if (p_sig !== es) begin
         failures++;
         $display("FAIL signature sel=%0d got=%h want=%h", s, p_sig, es);
      end
      checks++;
      if (p_pass !== 1'b1) begin
         failures++;
         $display("FAIL pass sel=%0d got=%b want=1", s, p_pass);
      end
      if (exp_stim.size() != 0) begin
         checks++; failures++;
         $display("FAIL vectors_missing sel=%0d got=%0d want=0", s, exp_stim.size());
         exp_stim.delete();
      end
   endtask

   task automatic test_reset();
      clear_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start_r[i] = 1'b0; seed_r[i] = 8'h00; exp_r[i] = 16'h0000;
      end
      #2 clear_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         checks++; if (p_stim !== 8'h00) begin failures++; $display("FAIL rst_stim sel=%0d got=%h want=00", s, p_stim); end
         checks++; if (p_clear !== 1'b1) begin failures++; $display("FAIL rst_clear sel=%0d got=%b want=1", s, p_clear); end
         checks++; if (p_busy !== 1'b0) begin failures++; $display("FAIL rst_busy sel=%0d got=%b want=0", s, p_busy); end
         checks++; if (p_done !== 1'b0) begin failures++; $display("FAIL rst_done sel=%0d got=%b want=0", s, p_done); end
         checks++; if (p_sig !== 16'h0000) begin failures++; $display("FAIL rst_sig sel=%0d got=%h want=0000", s, p_sig); end
         checks++; if (p_pass !== 1'b0) begin failures++; $display("FAIL rst_pass sel=%0d got=%b want=0", s, p_pass); end
      end
      @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      run_vectors(0, 8'hAA, 0);
      checks++;
      if (p_sig !== 16'h0101) begin failures++; $display("FAIL ident_sig got=%h want=0101", p_sig); end
      exp_r[0] = 16'h0100;
      #1;
      checks++;
      if (p_pass !== 1'b0) begin failures++; $display("FAIL ident_pass_wrong_exp got=%b want=0", p_pass); end
   endtask

   task automatic test_zero_long();
      run_vectors(1, 8'hAA, 0);
      checks++;
      if (p_sig !== 16'h0000) begin failures++; $display("FAIL zero_sig got=%h want=0000", p_sig); end
   endtask

   task automatic test_zero_seed();
      run_vectors(2, 8'h00, 0);
   endtask

   task automatic test_latency();
      run_vectors(3, 8'hAA, 0);
      checks++;
      if (p_sig !== 16'h0101) begin failures++; $display("FAIL lat_sig got=%h want=0101", p_sig); end
   endtask

   task automatic test_start_during_run();
      run_vectors(2, 8'h5A, 2);
   endtask

   task automatic test_restart_in_done();
      int unsigned done_cnt;
      bit got;
      sel = 0;
      @(negedge clk);
      exp_r[0] = 16'h0101; seed_r[0] = 8'hAA; start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      checks++; if (p_sig !== 16'h0000) begin failures++; $display("FAIL restart_sig_zero got=%h want=0000", p_sig); end
      checks++; if (p_busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b want=1", p_busy); end
      got = 0;
      for (int k = 0; k < 10; k++) begin
         if (p_done) begin got = 1; break; end
         @(negedge clk);
      end
      checks++; if (!got) begin failures++; $display("FAIL restart_timeout got=0 want=1"); end
      checks++; if (p_sig !== 16'h0101) begin failures++; $display("FAIL restart_sig got=%h want=0101", p_sig); end
      // start held high: a fresh run every N0+1 cycles
      start_r[0] = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (p_done) done_cnt++;
      end
      start_r[0] = 1'b0;
      checks++; if (done_cnt != 3) begin failures++; $display("FAIL held_start_runs got=%0d want=3", done_cnt); end
      @(negedge clk);
      checks++; if (p_done !== 1'b1) begin failures++; $display("FAIL held_start_final_done got=%b want=1", p_done); end
      checks++; if (p_sig !== 16'h0101) begin failures++; $display("FAIL held_start_sig got=%h want=0101", p_sig); end
   endtask

   task automatic test_reset_mid_run();
      sel = 1;
      @(negedge clk);
      seed_r[1] = 8'hAA; start_r[1] = 1'b1;
      @(negedge clk);
      start_r[1] = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (p_busy !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%b want=1", p_busy); end
      #3 clear_n = 1'b0;
      #1;
      checks++; if (p_stim !== 8'h00) begin failures++; $display("FAIL midrst_stim got=%h want=00", p_stim); end
      checks++; if (p_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", p_busy); end
      checks++; if (p_clear !== 1'b1) begin failures++; $display("FAIL midrst_clear got=%b want=1", p_clear); end
      checks++; if (p_done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", p_done); end
      sel = 0;
      #0.5;
      checks++; if (p_sig !== 16'h0000) begin failures++; $display("FAIL midrst_sig0 got=%h want=0000", p_sig); end
      checks++; if (p_done !== 1'b0) begin failures++; $display("FAIL midrst_done0 got=%b want=0", p_done); end
      @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk);
      run_vectors(1, 8'h3C, 0);
      run_vectors(0, 8'hAA, 0);
   endtask

   initial begin
      checks = 0; failures = 0; sel = 0;
      test_reset();
      test_identity();
      test_zero_long();
      test_zero_seed();
      test_latency();
      test_start_during_run();
      test_restart_in_done();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
